alu_multicycle: RTL and testbench

- Parametrised WIDTH-bit ALU that replaces the ripple of 1-bit slices with a registered, handshaked unit.
- Covers the slice ops AND/OR/ADD/SUB/NOR/NAND/SLT and the SLT compare modes (lt/gt/le/ge/eq/ne).
- Adds an iterative shift-add unsigned multiply that takes WIDTH cycles.
- Sits between the decode stage and writeback; the valid/ready handshake on both sides lets the multi-cycle op stall upstream.

---
 rtl/alu_defs.sv | 31 +++
 rtl/alu_comb_datapath.sv | 80 ++++++++
 rtl/alu_multicycle.sv | 149 ++++++++++++++
 tb/tb_alu_multicycle.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared opcode, compare-mode and FSM state definitions for the multicycle ALU.
package alu_defs;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b110;
  localparam logic [2:0] CMP_NE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // True for the only opcode that needs the iterative unit.
  function automatic logic is_mul_op(input logic [3:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_comb_datapath.sv
// Single-cycle ALU datapath: logic ops, add/sub with carry and signed
// overflow, and the signed compare used by SLT. Purely combinational.
module alu_comb_datapath
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_op,
  input  logic [2:0]       cmp_mode,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] src2_inv;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;
  logic             eq;
  logic             cond;

  // Subtraction reuses the adder form a + ~b + 1 so its carry means "no borrow".
  assign src2_inv = ~src2;
  assign add_sum  = {1'b0, src1} + {1'b0, src2};
  assign sub_sum  = {1'b0, src1} + {1'b0, src2_inv} + {{WIDTH{1'b0}}, 1'b1};

  // Signed overflow: both adder inputs agree in sign but the sum does not.
  assign add_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) &
                   (add_sum[WIDTH-1] != src1[WIDTH-1]);
  assign sub_ovf = (src1[WIDTH-1] == src2_inv[WIDTH-1]) &
                   (sub_sum[WIDTH-1] != src1[WIDTH-1]);

  // Signed less-than corrects the difference sign by the overflow bit.
  assign lt = sub_sum[WIDTH-1] ^ sub_ovf;
  assign eq = (src1 == src2);

  // Select the SLT condition for the requested compare mode.
  always_comb begin
    cond = 1'b0;
    case (cmp_mode)
      CMP_LT:  cond = lt;
      CMP_GT:  cond = ~(lt | eq);
      CMP_LE:  cond = lt | eq;
      CMP_GE:  cond = ~lt;
      CMP_EQ:  cond = eq;
      CMP_NE:  cond = ~eq;
      default: cond = 1'b0;
    endcase
  end

  // Opcode mux; unknown opcodes (and MUL, handled in the top) yield zeros.
  always_comb begin
    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (alu_op)
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_NOR:  result = ~(src1 | src2);
      ALU_NAND: result = ~(src1 & src2);
      ALU_ADD: begin
        result   = add_sum[WIDTH-1:0];
        cout     = add_sum[WIDTH];
        overflow = add_ovf;
      end
      ALU_SUB: begin
        result   = sub_sum[WIDTH-1:0];
        cout     = sub_sum[WIDTH];
        overflow = sub_ovf;
      end
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, cond};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered, handshaked ALU. Single-cycle ops finish in one edge; MUL runs
// an unsigned shift-add loop of WIDTH iterations before presenting a result.
module alu_multicycle
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       bonus_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  alu_state_t state_q;
  alu_state_t state_d;

  logic             accept;
  logic             load_single;
  logic             load_mul;
  logic             mul_finish;
  logic             mul_last;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   partial;
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] acc_step;

  logic [WIDTH-1:0] dp_result;
  logic             dp_cout;
  logic             dp_ovf;

  alu_comb_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .src1     (src1),
    .src2     (src2),
    .alu_op   (ALU_control),
    .cmp_mode (bonus_control),
    .result   (dp_result),
    .cout     (dp_cout),
    .overflow (dp_ovf)
  );

  // Ready depends only on state and the consumer, never on in_valid.
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);

  // One shift-add iteration: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  assign partial  = mplier_q[0] ? mcand_q : '0;
  assign hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, partial};
  assign acc_step = (2*WIDTH)'({hi_sum, acc_q[WIDTH-1:0]} >> 1);
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and load strobes for the datapath registers.
  always_comb begin
    state_d     = state_q;
    load_single = 1'b0;
    load_mul    = 1'b0;
    mul_finish  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_mul_op(ALU_control)) begin
            state_d  = ST_MUL;
            load_mul = 1'b1;
          end else begin
            state_d     = ST_DONE;
            load_single = 1'b1;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_d    = ST_DONE;
          mul_finish = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Multiply operand, accumulator and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_mul) begin
      mcand_q  <= src1;
      mplier_q <= src2;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == ST_MUL) begin
      acc_q    <= acc_step;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Output registers; they only change when a new result is produced, so a
  // stalled consumer always sees stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (load_single) begin
      result   <= dp_result;
      zero     <= (dp_result == '0);
      cout     <= dp_cout;
      overflow <= dp_ovf;
    end else if (mul_finish) begin
      result   <= acc_step[WIDTH-1:0];
      zero     <= (acc_step[WIDTH-1:0] == '0);
      cout     <= 1'b0;
      overflow <= |acc_step[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle with directed scenarios and a
// randomized sweep checked against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int WIDTH = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] src1 = '0;
  logic [WIDTH-1:0] src2 = '0;
  logic [3:0]       alu_control = '0;
  logic [2:0]       bonus_control = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  int total = 0;
  int bad = 0;

  alu_multicycle #(
    .WIDTH (WIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .src1          (src1),
    .src2          (src2),
    .ALU_control   (alu_control),
    .bonus_control (bonus_control),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .cout          (cout),
    .overflow      (overflow)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model: returns {result, zero, cout, overflow} from plain arithmetic.
  function automatic logic [WIDTH+2:0] model(input logic [3:0] op, input logic [2:0] cmp,
                                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint sa, sb, t;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0] r;
    logic c, v, cond;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; cond = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_ADD: begin
        r = a + b;
        c = ({32'b0, a} + {32'b0, b}) > 64'h0000_0000_FFFF_FFFF;
        t = sa + sb;
        v = (t > SMAX) || (t < SMIN);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        t = sa - sb;
        v = (t > SMAX) || (t < SMIN);
      end
      OP_SLT: begin
        case (cmp)
          3'b000: cond = (sa < sb);
          3'b001: cond = (sa > sb);
          3'b010: cond = (sa <= sb);
          3'b011: cond = (sa >= sb);
          3'b110: cond = (sa == sb);
          3'b100: cond = (sa != sb);
          default: cond = 1'b0;
        endcase
        r = {31'b0, cond};
      end
      OP_MUL: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[WIDTH-1:0];
        v = |p[2*WIDTH-1:WIDTH];
      end
      default: r = '0;
    endcase
    return {r, (r == '0), c, v};
  endfunction

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [2:0] cmp,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid      = 1'b1;
    alu_control   = op;
    bonus_control = cmp;
    src1          = a;
    src2          = b;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({out_valid, result, zero, cout, overflow} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got v=%0b r=%h z=%0b c=%0b o=%0b, need all 0",
               out_valid, result, zero, cout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got in_ready=%0b out_valid=%0b, need 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    drive(OP_ADD, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({out_valid, result, zero, cout, overflow} !== {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL add_overflow: got v=%0b r=%h z=%0b c=%0b o=%0b, need v=1 r=80000000 z=0 c=0 o=1",
               out_valid, result, zero, cout, overflow);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_drain: got out_valid=%0b, need 0", out_valid);
    end
  endtask

  task automatic test_sub_slt();
    logic [2:0] modes [6];
    logic       want  [6];
    modes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100};
    want  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    drive(OP_SUB, 3'b000, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    total++;
    if ({out_valid, result, zero, cout, overflow} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL sub_equal: got v=%0b r=%h z=%0b c=%0b o=%0b, need v=1 r=0 z=1 c=1 o=0",
               out_valid, result, zero, cout, overflow);
    end
    for (int i = 0; i < 6; i++) begin
      drive(OP_SLT, modes[i], 32'hFFFF_FFFF, 32'h0000_0001);
      @(negedge clk);
      total++;
      if ({out_valid, result, cout, overflow} !== {1'b1, 31'b0, want[i], 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL slt_mode%0b: got v=%0b r=%h c=%0b o=%0b, need r=%0d",
                 modes[i], out_valid, result, cout, overflow, want[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_r, input logic exp_ovf);
    int busy;
    int ready_bad;
    busy = 0;
    ready_bad = 0;
    out_ready = 1'b1;
    drive(OP_MUL, 3'b000, a, b);
    @(negedge clk);
    drive(OP_ADD, 3'b000, 32'($urandom()), 32'($urandom()));
    while (out_valid !== 1'b1 && busy < WIDTH + 10) begin
      if (in_ready !== 1'b0) ready_bad++;
      busy++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (busy != WIDTH || ready_bad != 0) begin
      bad++;
      $display("[TB] FAIL mul_latency: got busy=%0d ready_high=%0d, need busy=%0d ready_high=0",
               busy, ready_bad, WIDTH);
    end
    total++;
    if ({out_valid, result, zero, cout, overflow} !== {1'b1, exp_r, (exp_r == '0), 1'b0, exp_ovf}) begin
      bad++;
      $display("[TB] FAIL mul_result: got v=%0b r=%h z=%0b c=%0b o=%0b, need r=%h o=%0b",
               out_valid, result, zero, cout, overflow, exp_r, exp_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] a, b, c, d;
    logic [WIDTH+2:0] exp_and, exp_or;
    a = 32'($urandom()) | 32'h1; b = 32'($urandom()) | 32'h1;
    c = 32'($urandom()); d = 32'($urandom());
    exp_and = model(OP_AND, 3'b000, a, b);
    exp_or  = model(OP_OR, 3'b000, c, d);
    out_ready = 1'b0;
    drive(OP_AND, 3'b000, a, b);
    @(negedge clk);
    drive(OP_OR, 3'b000, c, d);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, in_ready, result, zero, cout, overflow} !== {1'b1, 1'b0, exp_and}) begin
        bad++;
        $display("[TB] FAIL hold_cycle%0d: got v=%0b rdy=%0b r=%h z=%0b c=%0b o=%0b, need v=1 rdy=0 r=%h",
                 i, out_valid, in_ready, result, zero, cout, overflow, exp_and[WIDTH+2:3]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({out_valid, result, zero, cout, overflow} !== {1'b1, exp_or}) begin
      bad++;
      $display("[TB] FAIL release_next: got v=%0b r=%h, need v=1 r=%h", out_valid, result, exp_or[WIDTH+2:3]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3];
    logic [WIDTH-1:0] a, b;
    logic [WIDTH+2:0] exp;
    ops = '{OP_OR, OP_NOR, OP_NAND};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'($urandom()); b = 32'($urandom());
      exp = model(ops[i], 3'b000, a, b);
      drive(ops[i], 3'b000, a, b);
      @(negedge clk);
      total++;
      if ({out_valid, result, zero, cout, overflow} !== {1'b1, exp}) begin
        bad++;
        $display("[TB] FAIL stream_op%0d: got v=%0b r=%h, need v=1 r=%h", i, out_valid, result, exp[WIDTH+2:3]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    logic [3:0] op_pool [10];
    logic [3:0] op;
    logic [2:0] cmp;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH+2:0] exp;
    int wait_cnt;
    int stall;
    op_pool = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_NAND, OP_SLT, OP_MUL, 4'b0011, 4'b1111};
    for (int k = 0; k < n; k++) begin
      op  = op_pool[$urandom_range(0, 9)];
      cmp = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      exp = model(op, cmp, a, b);
      out_ready = 1'b1;
      drive(op, cmp, a, b);
      @(negedge clk);
      in_valid = 1'b0;
      wait_cnt = 0;
      while (out_valid !== 1'b1 && wait_cnt < 2 * WIDTH) begin
        wait_cnt++;
        @(negedge clk);
      end
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      for (int s = 0; s < stall; s++) @(negedge clk);
      total++;
      if ({out_valid, result, zero, cout, overflow} !== {1'b1, exp}) begin
        bad++;
        $display("[TB] FAIL random%0d op=%b cmp=%b a=%h b=%h: got v=%0b r=%h z=%0b c=%0b o=%0b, need r=%h z=%0b c=%0b o=%0b",
                 k, op, cmp, a, b, out_valid, result, zero, cout, overflow,
                 exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen_valid;
    out_ready = 1'b1;
    drive(OP_ADD, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    drive(OP_MUL, 3'b000, 32'h0000_1234, 32'h0000_5678);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, result, zero, cout, overflow} !== '0) begin
      bad++;
      $display("[TB] FAIL midmul_reset: got v=%0b r=%h z=%0b c=%0b o=%0b, need all 0",
               out_valid, result, zero, cout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen_valid++;
    end
    total++;
    if (seen_valid != 0) begin
      bad++;
      $display("[TB] FAIL midmul_quiet: got %0d cycles with out_valid=1 or in_ready=0, need 0", seen_valid);
    end
    drive(OP_ADD, 3'b000, 32'd3, 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({out_valid, result, zero, cout, overflow} !== {1'b1, 32'd7, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL midmul_next_add: got v=%0b r=%h, need v=1 r=7", out_valid, result);
    end
    @(negedge clk);
  endtask

  // Absolute time limit so a stuck handshake can never hang the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_mul(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    test_mul(32'd7, 32'd6, 32'd42, 1'b0);
    test_backpressure();
    test_back_to_back();
    test_random(40);
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
